// File: rtl/mips_pkg.sv
// Shared types and constants for the Mini-MIPS fetch front end.
package mips_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_RUN,
        ST_HALT
    } fetch_state_t;

    localparam logic [5:0]  OP_J          = 6'h02;
    localparam logic [5:0]  OP_JAL        = 6'h03;
    localparam logic [31:0] HALT_INST_DEF = 32'hFC00_0000;

    // Branch word offset to byte offset, sign-extended wide enough for any XLEN up to 64.
    function automatic logic [63:0] sext_word_off(input logic [15:0] imm);
        return {{46{imm[15]}}, imm, 2'b00};
    endfunction

endpackage

// File: rtl/imem_array.sv
// Instruction memory: one synchronous write port, one asynchronous read port.
module imem_array #(
    parameter int XLEN   = 32,
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [XLEN-1:0]   wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [XLEN-1:0]   rdata
);

    logic [XLEN-1:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/mips_fetch_unit.sv
// Fetch front end: program load, PC sequencing with branch/jump/jr redirect,
// stall, halt-on-sentinel and sticky fault on bad targets.
//
// state   | meaning
// IDLE    | after reset, waiting for first load word or start
// LOAD    | streaming program words into memory at load_ptr
// RUN     | fetching one instruction per unstalled cycle
// HALT    | sentinel fetched or fault; only rst leaves
module mips_fetch_unit
    import mips_pkg::*;
#(
    parameter int              XLEN      = 32,
    parameter int              ADDR_W    = 10,
    parameter logic [XLEN-1:0] RESET_PC  = '0,
    parameter logic [XLEN-1:0] HALT_INST = XLEN'(HALT_INST_DEF)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_valid,
    input  logic [XLEN-1:0]   load_data,
    input  logic              start,
    input  logic              stall,
    input  logic              br_taken,
    input  logic [15:0]       br_imm,
    input  logic              jump_en,
    input  logic [25:0]       jump_idx,
    input  logic              jr_en,
    input  logic [XLEN-1:0]   jr_target,
    output logic [XLEN-1:0]   pc,
    output logic [XLEN-1:0]   pc_plus4,
    output logic [XLEN-1:0]   inst,
    output logic              inst_valid,
    output logic [ADDR_W-1:0] load_ptr,
    output logic              load_full,
    output logic              halted,
    output logic              fault
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

    fetch_state_t    state;
    logic [XLEN-1:0] next_pc;
    logic [XLEN-1:0] br_target;
    logic [XLEN-1:0] jump_target;
    logic            load_accept;
    logic            addr_fault;
    logic            is_halt_inst;

    imem_array #(
        .XLEN   (XLEN),
        .ADDR_W (ADDR_W)
    ) u_imem (
        .clk   (clk),
        .we    (load_accept),
        .waddr (load_ptr),
        .wdata (load_data),
        .raddr (pc[ADDR_W+1:2]),
        .rdata (inst)
    );

    assign pc_plus4    = pc + XLEN'(4);
    assign br_target   = pc_plus4 + XLEN'(sext_word_off(br_imm));
    assign jump_target = {pc[XLEN-1:28], jump_idx, 2'b00};

    always_comb begin
        next_pc = pc_plus4;
        if (br_taken) begin
            next_pc = br_target;
        end else if (jump_en) begin
            next_pc = jump_target;
        end else if (jr_en) begin
            next_pc = jr_target;
        end
    end

    // Target must be word aligned and land inside the implemented memory.
    assign addr_fault   = (next_pc[1:0] != 2'b00) || ((next_pc >> (ADDR_W + 2)) != '0);
    assign is_halt_inst = (inst == HALT_INST);

    // start wins over a coincident load strobe; a full memory drops further words.
    assign load_accept = load_valid && !start &&
                         ((state == ST_IDLE) || ((state == ST_LOAD) && !load_full));

    assign inst_valid = (state == ST_RUN) && !stall;
    assign halted     = (state == ST_HALT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            pc        <= RESET_PC;
            load_ptr  <= '0;
            load_full <= 1'b0;
            fault     <= 1'b0;
        end else begin
            case (state)
                ST_IDLE, ST_LOAD: begin
                    if (start) begin
                        state <= ST_RUN;
                        pc    <= RESET_PC;
                    end else if (load_accept) begin
                        state <= ST_LOAD;
                        if (load_ptr == LAST_ADDR) begin
                            load_full <= 1'b1;
                        end else begin
                            load_ptr <= load_ptr + ADDR_W'(1);
                        end
                    end
                end
                ST_RUN: begin
                    if (!stall) begin
                        if (is_halt_inst) begin
                            state <= ST_HALT;
                        end else if (addr_fault) begin
                            fault <= 1'b1;
                            state <= ST_HALT;
                        end else begin
                            pc <= next_pc;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mips_fetch_unit.sv
// Self-checking bench for mips_fetch_unit: directed scenarios plus a randomized
// run compared against a behavioural model of the fetch rules.
module tb_mips_fetch_unit;

    localparam int          DEPTH  = 1024;
    localparam logic [31:0] HALT_W = 32'hFC00_0000;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        load_valid, start, stall, br_taken, jump_en, jr_en;
    logic [31:0] load_data, jr_target;
    logic [15:0] br_imm;
    logic [25:0] jump_idx;
    logic [31:0] pc, pc_plus4, inst;
    logic        inst_valid, load_full, halted, fault;
    logic [9:0]  load_ptr;

    logic        s_load_valid, s_start, s_stall, s_br_taken, s_jump_en, s_jr_en;
    logic [31:0] s_load_data, s_jr_target;
    logic [15:0] s_br_imm;
    logic [25:0] s_jump_idx;
    logic [31:0] s_pc, s_pc_plus4, s_inst;
    logic        s_inst_valid, s_load_full, s_halted, s_fault;
    logic [3:0]  s_load_ptr;

    mips_fetch_unit #(.XLEN(32), .ADDR_W(10), .RESET_PC(32'h0), .HALT_INST(HALT_W)) dut (
        .clk(clk), .rst(rst), .load_valid(load_valid), .load_data(load_data),
        .start(start), .stall(stall), .br_taken(br_taken), .br_imm(br_imm),
        .jump_en(jump_en), .jump_idx(jump_idx), .jr_en(jr_en), .jr_target(jr_target),
        .pc(pc), .pc_plus4(pc_plus4), .inst(inst), .inst_valid(inst_valid),
        .load_ptr(load_ptr), .load_full(load_full), .halted(halted), .fault(fault)
    );

    mips_fetch_unit #(.XLEN(32), .ADDR_W(4), .RESET_PC(32'h0), .HALT_INST(HALT_W)) dut_small (
        .clk(clk), .rst(rst), .load_valid(s_load_valid), .load_data(s_load_data),
        .start(s_start), .stall(s_stall), .br_taken(s_br_taken), .br_imm(s_br_imm),
        .jump_en(s_jump_en), .jump_idx(s_jump_idx), .jr_en(s_jr_en), .jr_target(s_jr_target),
        .pc(s_pc), .pc_plus4(s_pc_plus4), .inst(s_inst), .inst_valid(s_inst_valid),
        .load_ptr(s_load_ptr), .load_full(s_load_full), .halted(s_halted), .fault(s_fault)
    );

    int total;
    int bad;

    // Reference model state: 0 idle, 1 load, 2 run, 3 halt.
    logic [31:0] m_mem [DEPTH];
    logic [31:0] prog  [4];
    int          m_state, m_ptr, loaded;
    logic [31:0] m_pc;
    logic        m_full, m_fault;

    function automatic logic [31:0] rand_word();
        logic [31:0] w = $urandom;
        if (w == HALT_W) w = 32'h0;
        return w;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        load_valid = 0; load_data = '0; start = 0; stall = 0; br_taken = 0; br_imm = '0;
        jump_en = 0; jump_idx = '0; jr_en = 0; jr_target = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        #2;
        rst = 1'b0;
    endtask

    task automatic start_run();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        s_load_valid = 0; s_load_data = '0; s_start = 0; s_stall = 0; s_br_taken = 0;
        s_br_imm = '0; s_jump_en = 0; s_jump_idx = '0; s_jr_en = 0; s_jr_target = '0;
        rst = 1'b1;
        #2;
        total++; if (pc !== 32'h0) begin bad++; $display("FAIL reset_pc got=%h exp=0", pc); end
        total++; if (load_ptr !== 10'd0) begin bad++; $display("FAIL reset_ptr got=%0d exp=0", load_ptr); end
        total++; if ({load_full, halted, fault, inst_valid} !== 4'b0) begin bad++;
            $display("FAIL reset_flags got=%b exp=0000", {load_full, halted, fault, inst_valid}); end
        total++; if ({s_load_full, s_halted, s_fault, s_inst_valid, s_load_ptr} !== 8'b0) begin bad++;
            $display("FAIL reset_small got=%b exp=0", {s_load_full, s_halted, s_fault, s_inst_valid, s_load_ptr}); end
        rst = 1'b0;
    endtask

    task automatic test_fill();
        do_reset();
        for (int i = 0; i < DEPTH; i++) begin
            m_mem[i] = rand_word();
            load_valid = 1'b1; load_data = m_mem[i];
            tick();
            if (i == DEPTH - 2) begin
                total++; if (load_full !== 1'b0 || load_ptr !== 10'd1023) begin bad++;
                    $display("FAIL fill_near_full full=%b ptr=%0d exp full=0 ptr=1023", load_full, load_ptr); end
            end
        end
        load_data = HALT_W;
        tick();
        load_valid = 1'b0;
        total++; if (load_full !== 1'b1 || load_ptr !== 10'd1023) begin bad++;
            $display("FAIL fill_full full=%b ptr=%0d exp full=1 ptr=1023", load_full, load_ptr); end
        start_run();
        jump_en = 1'b1; jump_idx = 26'd1023;
        tick();
        jump_en = 1'b0;
        total++; if (pc !== 32'hFFC) begin bad++; $display("FAIL fill_last_pc got=%h exp=ffc", pc); end
        total++; if (inst !== m_mem[1023]) begin bad++;
            $display("FAIL fill_drop inst got=%h exp=%h", inst, m_mem[1023]); end
    endtask

    task automatic test_program();
        prog[0] = 32'h0109_5020; prog[1] = 32'h2108_0001; prog[2] = 32'h1109_0004; prog[3] = HALT_W;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            m_mem[i] = prog[i];
            load_valid = 1'b1; load_data = prog[i];
            tick();
        end
        load_valid = 1'b0;
        total++; if (load_ptr !== 10'd4) begin bad++; $display("FAIL prog_ptr got=%0d exp=4", load_ptr); end
        start_run();
        for (int i = 0; i < 4; i++) begin
            total++; if (pc !== 32'(4 * i) || inst !== prog[i] || inst_valid !== 1'b1) begin bad++;
                $display("FAIL prog_step%0d pc=%h inst=%h v=%b exp pc=%h inst=%h v=1",
                         i, pc, inst, inst_valid, 32'(4 * i), prog[i]); end
            tick();
        end
        total++; if (halted !== 1'b1 || pc !== 32'hC || inst_valid !== 1'b0 || fault !== 1'b0) begin bad++;
            $display("FAIL prog_halt halted=%b pc=%h v=%b fault=%b exp 1 c 0 0", halted, pc, inst_valid, fault); end
        start_run();
        total++; if (halted !== 1'b1 || pc !== 32'hC) begin bad++;
            $display("FAIL halt_absorb halted=%b pc=%h exp 1 c", halted, pc); end
    endtask

    task automatic test_branch();
        do_reset();
        start_run();
        jump_en = 1'b1; jump_idx = 26'd8;
        tick();
        jump_en = 1'b0;
        total++; if (pc !== 32'h20) begin bad++; $display("FAIL br_setup pc got=%h exp=20", pc); end
        br_taken = 1'b1; br_imm = 16'hFFFE;
        tick();
        total++; if (pc !== 32'h1C) begin bad++; $display("FAIL br_back pc got=%h exp=1c", pc); end
        br_taken = 1'b0; jump_en = 1'b1; jump_idx = 26'd8;
        tick();
        jump_en = 1'b0; br_taken = 1'b1; br_imm = 16'd3;
        tick();
        br_taken = 1'b0;
        total++; if (pc !== 32'h30 || pc_plus4 !== 32'h34) begin bad++;
            $display("FAIL br_fwd pc=%h p4=%h exp 30 34", pc, pc_plus4); end
    endtask

    task automatic test_jump_fault();
        do_reset();
        start_run();
        jump_en = 1'b1; jump_idx = 26'd4;
        tick();
        jump_idx = 26'h40;
        total++; if (pc !== 32'h10) begin bad++; $display("FAIL j_setup pc got=%h exp=10", pc); end
        tick();
        jump_en = 1'b0;
        total++; if (pc !== 32'h100) begin bad++; $display("FAIL j_target pc got=%h exp=100", pc); end
        jr_en = 1'b1; jr_target = 32'h102;
        tick();
        jr_en = 1'b0;
        total++; if (fault !== 1'b1 || halted !== 1'b1 || pc !== 32'h100 || inst_valid !== 1'b0) begin bad++;
            $display("FAIL jr_fault fault=%b halted=%b pc=%h v=%b exp 1 1 100 0", fault, halted, pc, inst_valid); end
    endtask

    task automatic test_stall();
        do_reset();
        start_run();
        stall = 1'b1; br_taken = 1'b1; br_imm = 16'd5;
        for (int i = 0; i < 3; i++) begin
            #1;
            total++; if (inst_valid !== 1'b0) begin bad++; $display("FAIL stall_valid%0d got=%b exp=0", i, inst_valid); end
            tick();
            total++; if (pc !== 32'h0 || inst !== prog[0]) begin bad++;
                $display("FAIL stall_hold%0d pc=%h inst=%h exp 0 %h", i, pc, inst, prog[0]); end
        end
        stall = 1'b0; br_taken = 1'b0;
        #1;
        total++; if (inst_valid !== 1'b1) begin bad++; $display("FAIL stall_release_valid got=%b exp=1", inst_valid); end
        tick();
        total++; if (pc !== 32'h4) begin bad++; $display("FAIL stall_release_pc got=%h exp=4", pc); end
    endtask

    task automatic test_async_reset();
        do_reset();
        start_run();
        jump_en = 1'b1; jump_idx = 26'd9;
        tick();
        jump_en = 1'b0;
        total++; if (pc !== 32'h24) begin bad++; $display("FAIL areset_setup pc got=%h exp=24", pc); end
        #3;
        rst = 1'b1;
        #1;
        total++; if (pc !== 32'h0 || inst_valid !== 1'b0 || halted !== 1'b0) begin bad++;
            $display("FAIL areset_now pc=%h v=%b halted=%b exp 0 0 0", pc, inst_valid, halted); end
        #1;
        rst = 1'b0;
        tick();
        total++; if (pc !== 32'h0 || inst_valid !== 1'b0) begin bad++;
            $display("FAIL areset_idle pc=%h v=%b exp 0 0", pc, inst_valid); end
        start_run();
        for (int i = 0; i < 4; i++) begin
            total++; if (pc !== 32'(4 * i) || inst !== prog[i]) begin bad++;
                $display("FAIL areset_rerun%0d pc=%h inst=%h exp %h %h", i, pc, inst, 32'(4 * i), prog[i]); end
            tick();
        end
        total++; if (halted !== 1'b1 || pc !== 32'hC) begin bad++;
            $display("FAIL areset_halt halted=%b pc=%h exp 1 c", halted, pc); end
    endtask

    task automatic test_small_load();
        logic [31:0] sw [17];
        do_reset();
        for (int i = 0; i < 17; i++) sw[i] = rand_word();
        if (sw[16] == sw[15]) sw[16] = ~sw[15] & 32'h03FF_FFFF;
        for (int i = 0; i < 17; i++) begin
            s_load_valid = 1'b1; s_load_data = sw[i];
            tick();
            if (i == 14) begin
                total++; if (s_load_full !== 1'b0 || s_load_ptr !== 4'd15) begin bad++;
                    $display("FAIL small_15th full=%b ptr=%0d exp 0 15", s_load_full, s_load_ptr); end
            end
            if (i >= 15) begin
                total++; if (s_load_full !== 1'b1 || s_load_ptr !== 4'd15) begin bad++;
                    $display("FAIL small_full%0d full=%b ptr=%0d exp 1 15", i, s_load_full, s_load_ptr); end
            end
        end
        s_load_valid = 1'b0;
        s_start = 1'b1;
        tick();
        s_start = 1'b0;
        total++; if (s_inst !== sw[0]) begin bad++; $display("FAIL small_word0 got=%h exp=%h", s_inst, sw[0]); end
        s_jump_en = 1'b1; s_jump_idx = 26'd15;
        tick();
        total++; if (s_pc !== 32'h3C || s_inst !== sw[15] || s_fault !== 1'b0) begin bad++;
            $display("FAIL small_last pc=%h inst=%h fault=%b exp 3c %h 0", s_pc, s_inst, s_fault, sw[15]); end
        s_jump_idx = 26'd16;
        tick();
        s_jump_en = 1'b0;
        total++; if (s_fault !== 1'b1 || s_halted !== 1'b1 || s_pc !== 32'h3C) begin bad++;
            $display("FAIL small_range fault=%b halted=%b pc=%h exp 1 1 3c", s_fault, s_halted, s_pc); end
    endtask

    task automatic model_step();
        logic [31:0] nxt;
        int off;
        if (m_state == 0 || m_state == 1) begin
            if (start) begin
                m_state = 2; m_pc = 32'h0;
            end else if (load_valid && !m_full) begin
                m_mem[m_ptr] = load_data; loaded++; m_state = 1;
                if (m_ptr == DEPTH - 1) m_full = 1'b1; else m_ptr++;
            end
        end else if (m_state == 2 && !stall) begin
            if (m_mem[m_pc[11:2]] == HALT_W) begin
                m_state = 3;
            end else begin
                off = $signed(br_imm);
                if (br_taken)     nxt = m_pc + 32'd4 + 32'(off * 4);
                else if (jump_en) nxt = (m_pc & 32'hF000_0000) + 32'(jump_idx) * 32'd4;
                else if (jr_en)   nxt = jr_target;
                else              nxt = m_pc + 32'd4;
                if (nxt % 4 != 0 || nxt >= 32'(4 * DEPTH)) begin
                    m_fault = 1'b1; m_state = 3;
                end else begin
                    m_pc = nxt;
                end
            end
        end
    endtask

    task automatic test_random();
        int n;
        logic exp_v;
        for (int e = 0; e < 10; e++) begin
            do_reset();
            m_state = 0; m_pc = 32'h0; m_ptr = 0; m_full = 1'b0; m_fault = 1'b0; loaded = 0;
            n = $urandom_range(2, 12);
            for (int c = 0; c < 60; c++) begin
                idle_inputs();
                if (m_state < 2) begin
                    if (loaded < n) begin
                        load_valid = ($urandom_range(0, 3) != 0);
                        load_data  = ($urandom_range(0, 4) == 0) ? HALT_W : rand_word();
                    end else begin
                        start = 1'b1; load_valid = $urandom_range(0, 1) != 0; load_data = rand_word();
                    end
                end else begin
                    start      = (m_state == 3) && ($urandom_range(0, 1) != 0);
                    load_valid = $urandom_range(0, 1) != 0; load_data = rand_word();
                    stall      = ($urandom_range(0, 3) == 0);
                    br_taken   = ($urandom_range(0, 4) == 0);
                    br_imm     = 16'($urandom_range(0, 16)) - 16'd8;
                    jump_en    = ($urandom_range(0, 5) == 0);
                    jump_idx   = 26'($urandom_range(0, DEPTH - 1));
                    jr_en      = ($urandom_range(0, 5) == 0);
                    jr_target  = ($urandom_range(0, 7) == 0) ? $urandom : {20'h0, 10'($urandom_range(0, DEPTH - 1)), 2'b00};
                end
                #1;
                exp_v = (m_state == 2) && !stall;
                total++; if (pc !== m_pc) begin bad++; $display("FAIL rnd_pc e%0d c%0d got=%h exp=%h", e, c, pc, m_pc); end
                total++; if (pc_plus4 !== m_pc + 32'd4) begin bad++;
                    $display("FAIL rnd_pc4 e%0d c%0d got=%h exp=%h", e, c, pc_plus4, m_pc + 32'd4); end
                total++; if (inst !== m_mem[m_pc[11:2]]) begin bad++;
                    $display("FAIL rnd_inst e%0d c%0d got=%h exp=%h", e, c, inst, m_mem[m_pc[11:2]]); end
                total++; if (inst_valid !== exp_v) begin bad++;
                    $display("FAIL rnd_valid e%0d c%0d got=%b exp=%b", e, c, inst_valid, exp_v); end
                total++; if (halted !== (m_state == 3) || fault !== m_fault) begin bad++;
                    $display("FAIL rnd_halt e%0d c%0d halted=%b fault=%b exp %b %b", e, c, halted, fault, m_state == 3, m_fault); end
                total++; if (load_ptr !== 10'(m_ptr) || load_full !== m_full) begin bad++;
                    $display("FAIL rnd_load e%0d c%0d ptr=%0d full=%b exp %0d %b", e, c, load_ptr, load_full, m_ptr, m_full); end
                tick();
                model_step();
            end
        end
        idle_inputs();
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_fill();
        test_program();
        test_branch();
        test_jump_fault();
        test_stall();
        test_async_reset();
        test_small_load();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
